// File: rtl/seq_det_pkg.sv
// Shared constants for the parameterised serial pattern detector.
package seq_det_pkg;

  // Default pattern length, counter width and power-up pattern
  localparam int                     DEF_PAT_W     = 4;
  localparam int                     DEF_CNT_W     = 8;
  localparam logic [DEF_PAT_W-1:0]   DEF_RESET_PAT = 4'b1011;

  // Overlap-mode encodings for the OVERLAP parameter
  localparam int                     OVERLAP_OFF   = 0;
  localparam int                     OVERLAP_ON    = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear that coincides
// with an increment leaves the counter at 1 so that event is not lost.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_reg;

  // Counter register: clear wins, increment stops at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a loadable pattern, overlap or
// non-overlap matching, a registered match pulse and a match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = DEF_PAT_W,
  parameter int               OVERLAP   = OVERLAP_ON,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEF_RESET_PAT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       x,
  input  logic                       load_pat,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic                       clr_cnt,
  output logic                       w,
  output logic [$clog2(PAT_W+1)-1:0] fill,
  output logic [CNT_W-1:0]           match_count
);

  localparam int                FILL_W    = $clog2(PAT_W+1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_reg;
  logic [PAT_W-1:0]  hist_next;
  logic [PAT_W-1:0]  hist_shift;
  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  pat_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic [FILL_W-1:0] fill_inc;
  logic              match;
  logic              w_reg;

  // Next-state and match evaluation; the match looks at the post-shift
  // history so the pulse follows the edge that takes in the last bit
  always_comb begin
    hist_shift = {hist_reg[PAT_W-2:0], x};
    fill_inc   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);
    match      = en && !load_pat && (fill_inc == FILL_FULL) && (hist_shift == pat_reg);
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    pat_next   = pat_reg;
    if (load_pat) begin
      // A new pattern invalidates the history; the incoming x is dropped
      pat_next  = pat_in;
      hist_next = '0;
      fill_next = '0;
    end else if (en) begin
      hist_next = hist_shift;
      // Non-overlap mode demands a full set of fresh bits after each hit
      fill_next = (match && (OVERLAP == OVERLAP_OFF)) ? '0 : fill_inc;
    end
  end

  // State registers; reset restores the power-up pattern
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= RESET_PAT;
      w_reg    <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      pat_reg  <= pat_next;
      w_reg    <= match;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (clr_cnt),
    .count (match_count)
  );

  assign w    = w_reg;
  assign fill = fill_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus stream; a behavioural model pushes
// expected outputs to a scoreboard that is popped after each clock edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       load_pat = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clr_cnt = 1'b0;

  logic       w_a, w_b, w_c;
  logic [2:0] f_a, f_b, f_c;
  logic [7:0] c_a, c_b;
  logic [1:0] c_c;

  int n_total = 0;
  int n_pass  = 0;
  int pulses [3];

  typedef struct {
    logic [3:0] hist;
    int         fill;
    logic [3:0] pat;
    int         cnt;
    logic       w;
  } m_t;

  typedef struct packed {
    logic [2:0]      w;
    logic [2:0][2:0] fill;
    logic [2:0][7:0] cnt;
  } exp_t;

  m_t   mdl [3];
  exp_t sb [$];
  int   ovl_cfg [3]  = '{1, 0, 1};
  int   cmax_cfg [3] = '{255, 255, 3};

  always #5 clk = ~clk;

  seq_detector_param #(.OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .x(x), .load_pat(load_pat),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .w(w_a), .fill(f_a), .match_count(c_a));

  seq_detector_param #(.OVERLAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .en(en), .x(x), .load_pat(load_pat),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .w(w_b), .fill(f_b), .match_count(c_b));

  seq_detector_param #(.OVERLAP(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .en(en), .x(x), .load_pat(load_pat),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .w(w_c), .fill(f_c), .match_count(c_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic m_t model_reset();
    m_t m;
    m.hist = 4'b0000;
    m.fill = 0;
    m.pat  = 4'b1011;
    m.cnt  = 0;
    m.w    = 1'b0;
    return m;
  endfunction

  // Behaviour of one clock edge taken straight from the requirements
  function automatic m_t model(input m_t m, input logic e, input logic xi, input logic ld,
                               input logic [3:0] pi, input logic clr, input int ovl, input int cmax);
    logic hit;
    hit = 1'b0;
    if (ld) begin
      m.pat  = pi;
      m.hist = 4'b0000;
      m.fill = 0;
    end else if (e) begin
      m.hist = {m.hist[2:0], xi};
      if (m.fill < 4) m.fill = m.fill + 1;
      hit = (m.fill == 4) && (m.hist == m.pat);
      if (hit && ovl == 0) m.fill = 0;
    end
    if (clr) m.cnt = hit ? 1 : 0;
    else if (hit && m.cnt < cmax) m.cnt = m.cnt + 1;
    m.w = hit;
    return m;
  endfunction

  function automatic logic [31:0] obs_w(input int i);
    case (i)
      0:       return {31'd0, w_a};
      1:       return {31'd0, w_b};
      default: return {31'd0, w_c};
    endcase
  endfunction

  function automatic logic [31:0] obs_f(input int i);
    case (i)
      0:       return {29'd0, f_a};
      1:       return {29'd0, f_b};
      default: return {29'd0, f_c};
    endcase
  endfunction

  function automatic logic [31:0] obs_c(input int i);
    case (i)
      0:       return {24'd0, c_a};
      1:       return {24'd0, c_b};
      default: return {30'd0, c_c};
    endcase
  endfunction

  // Drive one cycle of stimulus, push the model's prediction, then pop
  // and compare against all three instances just after the edge
  task automatic step(input logic e, input logic xi, input logic ld = 1'b0,
                      input logic [3:0] pi = 4'b0000, input logic clr = 1'b0);
    exp_t ex;
    exp_t got;
    en = e; x = xi; load_pat = ld; pat_in = pi; clr_cnt = clr;
    for (int i = 0; i < 3; i++) begin
      mdl[i]     = model(mdl[i], e, xi, ld, pi, clr, ovl_cfg[i], cmax_cfg[i]);
      ex.w[i]    = mdl[i].w;
      ex.fill[i] = mdl[i].fill[2:0];
      ex.cnt[i]  = mdl[i].cnt[7:0];
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w[%0d] t=%0t", i, $time), obs_w(i), {31'd0, got.w[i]});
      check($sformatf("fill[%0d] t=%0t", i, $time), obs_f(i), {29'd0, got.fill[i]});
      check($sformatf("cnt[%0d] t=%0t", i, $time), obs_c(i), {24'd0, got.cnt[i]});
      if (obs_w(i) == 32'd1) pulses[i]++;
    end
    $display("step t=%0t en=%0b x=%0b ld=%0b pat=%b clr=%0b | w=%0b%0b%0b fill=%0d/%0d/%0d cnt=%0d/%0d/%0d",
             $time, e, xi, ld, pi, clr, w_a, w_b, w_c, f_a, f_b, f_c, c_a, c_b, c_c);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) mdl[i] = model_reset();
    clear_pulses();

    // Reset state while reset is held low across clock edges
    #22;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_w[%0d]", i), obs_w(i), 32'd0);
      check($sformatf("rst_fill[%0d]", i), obs_f(i), 32'd0);
      check($sformatf("rst_cnt[%0d]", i), obs_c(i), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Stream 1011011: overlap hits twice, non-overlap once and ends at fill 3
    step(1, 1); step(1, 0); step(1, 1); step(1, 1);
    step(1, 0); step(1, 1); step(1, 1);
    check("ovl_pulses", pulses[0], 32'd2);
    check("novl_pulses", pulses[1], 32'd1);
    check("ovl_cnt", {24'd0, c_a}, 32'd2);
    check("novl_cnt", {24'd0, c_b}, 32'd1);
    check("novl_fill_end", {29'd0, f_b}, 32'd3);

    // Clear alone
    step(0, 0, 0, 4'b0000, 1);
    check("clr_alone", {24'd0, c_a}, 32'd0);

    // Gap with en=0 inside a partial match
    step(0, 0, 1, 4'b1011);
    clear_pulses();
    step(1, 1); step(1, 0); step(1, 1);
    for (int k = 0; k < 5; k++) step(0, k[0]);
    check("gap_no_pulse", pulses[0], 32'd0);
    step(1, 1);
    check("gap_resume_w", {31'd0, w_a}, 32'd1);
    check("gap_pulses", pulses[0], 32'd1);

    // Load with en=1 in the same cycle discards x
    step(1, 1, 1, 4'b0110);
    check("load_fill", {29'd0, f_a}, 32'd0);
    clear_pulses();
    step(1, 0); step(1, 1); step(1, 1); step(1, 0);
    check("load_match_w", {31'd0, w_a}, 32'd1);
    check("load_pulses", pulses[0], 32'd1);

    // Six overlapping matches saturate the 2-bit counter
    step(0, 0, 0, 4'b0000, 1);
    step(0, 0, 1, 4'b0110);
    step(1, 0); step(1, 1); step(1, 1); step(1, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1); step(1, 1); step(1, 0);
    end
    check("sat_cnt_c", {30'd0, c_c}, 32'd3);
    check("cnt6_a", {24'd0, c_a}, 32'd6);
    step(1, 1); step(1, 1); step(1, 0, 0, 4'b0000, 1);
    check("clr_with_match_c", {30'd0, c_c}, 32'd1);
    check("clr_with_match_w", {31'd0, w_c}, 32'd1);

    // Asynchronous reset mid-sequence, pattern returns to 1011
    step(0, 0, 1, 4'b1001);
    step(1, 1); step(1, 0); step(1, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_w", {31'd0, w_a}, 32'd0);
    check("async_fill", {29'd0, f_a}, 32'd0);
    check("async_cnt", {24'd0, c_a}, 32'd0);
    for (int i = 0; i < 3; i++) mdl[i] = model_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_pulses();
    step(1, 1);
    check("post_rst_w", {31'd0, w_a}, 32'd0);
    check("post_rst_fill", {29'd0, f_a}, 32'd1);
    step(1, 0); step(1, 1); step(1, 1);
    check("post_rst_pat_w", {31'd0, w_a}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width.
REQ-004 SHALL have parameter RESET_PAT, default 4'b1011 (PAT_W bits): pattern held after reset.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  x is sampled only when en=1.
REQ-008 SHALL have port x  input  1  serial data bit.
REQ-009 SHALL have port load_pat  input  1  load pat_in into the pattern register.
REQ-010 SHALL have port pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit expected.
REQ-011 SHALL have port clr_cnt  input  1  synchronous clear of match_count.
REQ-012 SHALL have port w  output  1  one-cycle match pulse, registered.
REQ-013 SHALL have port fill  output  $clog2(PAT_W+1)  count of valid history bits, 0..PAT_W.
REQ-014 SHALL have port match_count  output  CNT_W  saturating count of matches.

Function
REQ-015 SHALL keep history register hist (PAT_W bits); on en=1: hist <= {hist[PAT_W-2:0], x}.
REQ-016 SHALL increment fill on each en=1 cycle, saturating at PAT_W; hold when en=0.
REQ-017 SHALL flag a match when en=1, the post-shift fill equals PAT_W, and the post-shift hist equals the pattern register.
REQ-018 SHALL assert w for exactly the one cycle following the clock edge that sampled the final pattern bit, and deassert it otherwise.
REQ-019 SHALL leave fill at PAT_W after a match when OVERLAP=1, so history bits are reused.
REQ-020 SHALL set fill to 0 on a match when OVERLAP=0, so the next match needs PAT_W fresh bits.
REQ-021 SHALL increment match_count by 1 per match, saturating at 2^CNT_W-1 with no wrap.
REQ-022 SHALL, on load_pat=1: load pat_in, clear hist and fill to 0, and suppress any match in that cycle.
REQ-023 SHALL let load_pat take priority over en=1 in the same cycle; the x bit is discarded.
REQ-024 SHALL clear match_count to 0 on clr_cnt=1 alone.
REQ-025 SHALL load match_count with 1 when clr_cnt=1 coincides with a match.
REQ-026 SHALL have no combinational path from any input to any output.

Reset
REQ-027 SHALL, while reset=0, force hist=0, fill=0, w=0, match_count=0 and pattern register=RESET_PAT, regardless of clk.
REQ-028 SHALL discard any partial match when reset asserts mid-sequence; detection restarts from fill=0 after release.
REQ-029 SHALL sample en on the first rising clk edge after reset deasserts.

Structure
REQ-030 SHALL place in shared package seq_det_pkg: the default PAT_W, CNT_W and RESET_PAT constants and the overlap-mode encoding constants.
REQ-031 SHALL implement match_count in one sub-module, sat_counter (parameter CNT_W; inputs inc, clr; output count), instantiated once.
REQ-032 SHALL implement the history shifter, fill counter and match logic in the top module.

Verification (PAT_W=4, pattern 1011, CNT_W=8 unless stated)
REQ-033 SHALL cover: OVERLAP=1, en=1, x=1,0,1,1,0,1,1 -> w pulses after the 4th and 7th bits; match_count=2.
REQ-034 SHALL cover: OVERLAP=0, same stream -> w pulses only after the 4th bit; match_count=1; fill=3 at end.
REQ-035 SHALL cover: x=1,0,1 with en=1, then en=0 for 5 cycles, then x=1 with en=1 -> no w pulse during the gap; one pulse after the resumed bit.
REQ-036 SHALL cover: load_pat=1, pat_in=0110, en=1 in the same cycle, then stream 0,1,1,0 -> fill=0 after the load cycle; one match after the 4th bit.
REQ-037 SHALL cover: CNT_W=2, six matches -> match_count saturates at 3; clr_cnt coinciding with a match -> match_count=1.
REQ-038 SHALL cover: reset=0 asserted asynchronously after x=1,0,1 -> w=0, fill=0 immediately; a following 1 does not match.
